// File: rtl/ddr_cas_sched_pkg.sv
// Shared types and default timing for the DDR4 CAS scheduler.
package ddr_cas_sched_pkg;

    typedef enum logic [1:0] {
        CAS_IDLE,
        CAS_WAIT,
        CAS_ISSUE
    } cas_fsm_type;

    // Access direction encodings shared with the ACT sequencer
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;

    // Default DDR4 timing in controller clocks
    localparam int unsigned DEF_TRCD = 11;
    localparam int unsigned DEF_TCCD = 4;
    localparam int unsigned DEF_WL   = 9;
    localparam int unsigned DEF_TWTR = 6;
    localparam int unsigned DEF_TRTW = 8;

    // Gap counter width and its saturation value
    localparam int unsigned GAP_CNT_W = 6;
    localparam int unsigned GAP_MAX   = 63;

    // True when every turnaround gap fits below the gap counter ceiling
    function automatic bit gaps_fit(input int unsigned tccd, input int unsigned wl,
                                    input int unsigned twtr, input int unsigned trtw);
        return (tccd < GAP_MAX) && ((wl + 4 + twtr) < GAP_MAX) && (trtw < GAP_MAX);
    endfunction

endpackage

// File: rtl/ddr_cas_sched_gap.sv
// Tracks cycles since the last CAS and flags when the next one may go.
module cas_gap_timer
    import ddr_cas_sched_pkg::*;
#(
    parameter int unsigned TCCD = DEF_TCCD,
    parameter int unsigned WL   = DEF_WL,
    parameter int unsigned TWTR = DEF_TWTR,
    parameter int unsigned TRTW = DEF_TRTW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic       last_vld,
    input  logic [1:0] last_rw,
    input  logic [1:0] next_rw,
    output logic       gap_ok
);

    if (!gaps_fit(TCCD, WL, TWTR, TRTW)) begin : g_gap_check
        $error("cas_gap_timer: a turnaround gap does not fit the 6-bit gap counter");
    end

    localparam logic [GAP_CNT_W:0] GAP_SAME = (GAP_CNT_W + 1)'(TCCD);
    localparam logic [GAP_CNT_W:0] GAP_W2R  = (GAP_CNT_W + 1)'(WL + 4 + TWTR);
    localparam logic [GAP_CNT_W:0] GAP_R2W  = (GAP_CNT_W + 1)'(TRTW);

    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    logic [GAP_CNT_W:0]   elapsed;

    // Zero on issue, otherwise count up and hold at the ceiling
    always_comb begin
        gap_d = gap_q;
        if (issue) begin
            gap_d = '0;
        end else if (gap_q != GAP_CNT_W'(GAP_MAX)) begin
            gap_d = gap_q + GAP_CNT_W'(1);
        end
    end

    // Judged the cycle before the CAS would go out, so compare the spacing
    // that CAS would have: counter is 0 one cycle after an issue, hence +2.
    always_comb begin
        elapsed = {1'b0, gap_q} + (GAP_CNT_W + 1)'(2);
        gap_ok  = 1'b1;
        if (last_vld) begin
            if (last_rw == next_rw) begin
                gap_ok = (elapsed >= GAP_SAME);
            end else if (last_rw == WRITE) begin
                gap_ok = (elapsed >= GAP_W2R);
            end else begin
                gap_ok = (elapsed >= GAP_R2W);
            end
        end
    end

    // Gap counter register, saturated out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= GAP_CNT_W'(GAP_MAX);
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/ddr_cas_sched.sv
// CAS scheduler: queues up to two column accesses and issues them in order
// once tRCD and the direction-dependent CAS spacing are satisfied.
module ddr_cas_sched
    import ddr_cas_sched_pkg::*;
#(
    parameter int unsigned TRCD  = DEF_TRCD,
    parameter int unsigned TCCD  = DEF_TCCD,
    parameter int unsigned WL    = DEF_WL,
    parameter int unsigned TWTR  = DEF_TWTR,
    parameter int unsigned TRTW  = DEF_TRTW,
    parameter int unsigned COL_W = 10
) (
    input  logic             clock_t,
    input  logic             reset,
    input  logic             act_rdy,
    input  logic             no_act_rdy,
    input  logic [1:0]       act_rw,
    input  logic [COL_W-1:0] col_addr,
    output logic             cas_rdy,
    output logic [1:0]       cas_rw,
    output logic [COL_W-1:0] cas_col,
    output logic             cas_idle,
    output logic             q_full,
    output logic             err_ovf
);

    localparam int unsigned     RCD_W    = (TRCD > 2) ? $clog2(TRCD) : 1;
    localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(TRCD - 1);

    cas_fsm_type      state_q, state_d;
    logic [1:0]       q_rw_q  [2];
    logic [1:0]       q_rw_d  [2];
    logic [COL_W-1:0] q_col_q [2];
    logic [COL_W-1:0] q_col_d [2];
    logic [RCD_W-1:0] q_rcd_q [2];
    logic [RCD_W-1:0] q_rcd_d [2];
    logic [1:0]       cnt_q, cnt_d, cnt_pop;
    logic             err_ovf_q, err_ovf_d;
    logic             q_full_q, q_full_d;
    logic             cas_rdy_q, cas_rdy_d;
    logic             cas_idle_q, cas_idle_d;
    logic [1:0]       cas_rw_q, cas_rw_d;
    logic [COL_W-1:0] cas_col_q, cas_col_d;
    logic             last_vld_q, last_vld_d;
    logic             push, pop, head_ok, gap_ok;

    cas_gap_timer #(
        .TCCD (TCCD),
        .WL   (WL),
        .TWTR (TWTR),
        .TRTW (TRTW)
    ) u_gap (
        .clk      (clock_t),
        .rst      (reset),
        .issue    (pop),
        .last_vld (last_vld_q),
        .last_rw  (cas_rw_q),
        .next_rw  (q_rw_q[0]),
        .gap_ok   (gap_ok)
    );

    // Queue update: age tRCD counters, pop the head on issue, then push
    always_comb begin
        push = act_rdy | no_act_rdy;
        pop  = (state_q == CAS_ISSUE);
        for (int unsigned i = 0; i < 2; i++) begin
            q_rw_d[i]  = q_rw_q[i];
            q_col_d[i] = q_col_q[i];
            q_rcd_d[i] = (q_rcd_q[i] != '0) ? q_rcd_q[i] - RCD_W'(1) : '0;
        end
        cnt_pop = cnt_q;
        if (pop) begin
            q_rw_d[0]  = q_rw_q[1];
            q_col_d[0] = q_col_q[1];
            q_rcd_d[0] = q_rcd_d[1];
            cnt_pop    = cnt_q - 2'd1;
        end
        cnt_d     = cnt_pop;
        err_ovf_d = err_ovf_q | (act_rdy & no_act_rdy);
        if (push) begin
            if (cnt_pop == 2'd2) begin
                err_ovf_d = 1'b1;
            end else begin
                q_rw_d[cnt_pop[0]]  = act_rw;
                q_col_d[cnt_pop[0]] = col_addr;
                q_rcd_d[cnt_pop[0]] = act_rdy ? RCD_LOAD : '0;
                cnt_d               = cnt_pop + 2'd1;
            end
        end
        q_full_d = (cnt_d == 2'd2);
        // Head counter reaches zero in the issue cycle itself
        head_ok  = (cnt_q != 2'd0) && (q_rcd_q[0] <= RCD_W'(1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAS_IDLE:  if (push) state_d = CAS_WAIT;
            CAS_WAIT:  if (head_ok && gap_ok) state_d = CAS_ISSUE;
            CAS_ISSUE: state_d = (cnt_d != 2'd0) ? CAS_WAIT : CAS_IDLE;
            default:   state_d = CAS_IDLE;
        endcase
    end

    // Registered outputs follow the upcoming state
    always_comb begin
        cas_rdy_d  = (state_d == CAS_ISSUE);
        cas_idle_d = (state_d == CAS_IDLE);
        cas_rw_d   = cas_rw_q;
        cas_col_d  = cas_col_q;
        if (state_d == CAS_ISSUE) begin
            cas_rw_d  = q_rw_q[0];
            cas_col_d = q_col_q[0];
        end
        last_vld_d = last_vld_q | cas_rdy_q;
    end

    // State, queue and output registers
    always_ff @(posedge clock_t) begin
        if (reset) begin
            state_q    <= CAS_IDLE;
            cnt_q      <= '0;
            err_ovf_q  <= 1'b0;
            q_full_q   <= 1'b0;
            cas_rdy_q  <= 1'b0;
            cas_idle_q <= 1'b1;
            cas_rw_q   <= '0;
            cas_col_q  <= '0;
            last_vld_q <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                q_rw_q[i]  <= '0;
                q_col_q[i] <= '0;
                q_rcd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_ovf_q  <= err_ovf_d;
            q_full_q   <= q_full_d;
            cas_rdy_q  <= cas_rdy_d;
            cas_idle_q <= cas_idle_d;
            cas_rw_q   <= cas_rw_d;
            cas_col_q  <= cas_col_d;
            last_vld_q <= last_vld_d;
            for (int unsigned i = 0; i < 2; i++) begin
                q_rw_q[i]  <= q_rw_d[i];
                q_col_q[i] <= q_col_d[i];
                q_rcd_q[i] <= q_rcd_d[i];
            end
        end
    end

    assign cas_rdy  = cas_rdy_q;
    assign cas_rw   = cas_rw_q;
    assign cas_col  = cas_col_q;
    assign cas_idle = cas_idle_q;
    assign q_full   = q_full_q;
    assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_ddr_cas_sched.sv
// Directed-vector bench for ddr_cas_sched with hand-computed issue times.
module tb_ddr_cas_sched;
    import ddr_cas_sched_pkg::*;

    localparam int LEN = 40;

    logic       clk;
    logic       reset;
    logic       act_rdy;
    logic       no_act_rdy;
    logic [1:0] act_rw;
    logic [9:0] col_addr;
    logic       cas_rdy;
    logic [1:0] cas_rw;
    logic [9:0] cas_col;
    logic       cas_idle;
    logic       q_full;
    logic       err_ovf;

    int checks = 0;
    int errors = 0;

    // Scenario tables
    int         n_ev, n_exp, n_pr, rst_cyc;
    int         ev_cyc [4];
    int         ev_kind[4];   // 0 act, 1 hit, 2 both pulses
    logic [1:0] ev_rw  [4];
    logic [9:0] ev_col [4];
    int         exp_cyc[4];
    logic [1:0] exp_rw [4];
    logic [9:0] exp_col[4];
    int         pr_cyc [8];
    int         pr_sig [8];   // 0 idle, 1 q_full, 2 err_ovf, 3 rw, 4 col, 5 rdy
    int         pr_val [8];

    ddr_cas_sched #(
        .TRCD  (11),
        .TCCD  (4),
        .WL    (9),
        .TWTR  (6),
        .TRTW  (8),
        .COL_W (10)
    ) dut (
        .clock_t    (clk),
        .reset      (reset),
        .act_rdy    (act_rdy),
        .no_act_rdy (no_act_rdy),
        .act_rw     (act_rw),
        .col_addr   (col_addr),
        .cas_rdy    (cas_rdy),
        .cas_rw     (cas_rw),
        .cas_col    (cas_col),
        .cas_idle   (cas_idle),
        .q_full     (q_full),
        .err_ovf    (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int sig);
        case (sig)
            0:       return {31'd0, cas_idle};
            1:       return {31'd0, q_full};
            2:       return {31'd0, err_ovf};
            3:       return {30'd0, cas_rw};
            4:       return {22'd0, cas_col};
            default: return {31'd0, cas_rdy};
        endcase
    endfunction

    task automatic clr();
        n_ev = 0; n_exp = 0; n_pr = 0; rst_cyc = -1;
    endtask

    task automatic add_ev(input int c, input int k, input logic [1:0] rw, input logic [9:0] col);
        ev_cyc[n_ev] = c; ev_kind[n_ev] = k; ev_rw[n_ev] = rw; ev_col[n_ev] = col;
        n_ev++;
    endtask

    task automatic add_exp(input int c, input logic [1:0] rw, input logic [9:0] col);
        exp_cyc[n_exp] = c; exp_rw[n_exp] = rw; exp_col[n_exp] = col;
        n_exp++;
    endtask

    task automatic add_pr(input int c, input int s, input int v);
        pr_cyc[n_pr] = c; pr_sig[n_pr] = s; pr_val[n_pr] = v;
        n_pr++;
    endtask

    task automatic run_scn(input string name);
        int         n_obs;
        int         obs_cyc[8];
        logic [1:0] obs_rw [8];
        logic [9:0] obs_col[8];
        reset = 1'b1; act_rdy = 1'b0; no_act_rdy = 1'b0; act_rw = '0; col_addr = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        chk({name, " rst rdy"},  {31'd0, cas_rdy},  0);
        chk({name, " rst idle"}, {31'd0, cas_idle}, 1);
        chk({name, " rst full"}, {31'd0, q_full},   0);
        chk({name, " rst ovf"},  {31'd0, err_ovf},  0);
        chk({name, " rst rw"},   {30'd0, cas_rw},   0);
        chk({name, " rst col"},  {22'd0, cas_col},  0);
        n_obs = 0;
        for (int t = 0; t <= LEN; t++) begin
            if (cas_rdy === 1'b1) begin
                if (n_obs < 8) begin
                    obs_cyc[n_obs] = t; obs_rw[n_obs] = cas_rw; obs_col[n_obs] = cas_col;
                end
                n_obs++;
            end
            for (int p = 0; p < n_pr; p++) begin
                if (pr_cyc[p] == t)
                    chk($sformatf("%s probe%0d@%0d", name, pr_sig[p], t), probe(pr_sig[p]), pr_val[p]);
            end
            act_rdy = 1'b0; no_act_rdy = 1'b0;
            reset = (t == rst_cyc);
            for (int e = 0; e < n_ev; e++) begin
                if (ev_cyc[e] == t) begin
                    act_rdy    = (ev_kind[e] != 1);
                    no_act_rdy = (ev_kind[e] != 0);
                    act_rw     = ev_rw[e];
                    col_addr   = ev_col[e];
                end
            end
            @(posedge clk); #1;
        end
        act_rdy = 1'b0; no_act_rdy = 1'b0; reset = 1'b0;
        chk({name, " n_issue"}, n_obs, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < n_obs && i < 8) begin
                chk($sformatf("%s issue%0d cyc", name, i), obs_cyc[i], exp_cyc[i]);
                chk($sformatf("%s issue%0d rw", name, i),  {30'd0, obs_rw[i]},  {30'd0, exp_rw[i]});
                chk($sformatf("%s issue%0d col", name, i), {22'd0, obs_col[i]}, {22'd0, exp_col[i]});
            end
        end
    endtask

    initial begin
        // ACT then READ: tRCD of 11
        clr();
        add_ev(10, 0, READ, 10'h155);
        add_exp(21, READ, 10'h155);
        add_pr(10, 0, 1); add_pr(11, 0, 0); add_pr(21, 0, 0); add_pr(22, 0, 1); add_pr(11, 1, 0);
        run_scn("act_rd");

        // Back-to-back write hits: tCCD
        clr();
        add_ev(5, 1, WRITE, 10'h011); add_ev(6, 1, WRITE, 10'h022);
        add_exp(7, WRITE, 10'h011); add_exp(11, WRITE, 10'h022);
        add_pr(6, 0, 0); add_pr(7, 1, 1); add_pr(8, 1, 0); add_pr(12, 0, 1);
        run_scn("b2b_wr");

        // Write to read turnaround: WL+4+tWTR = 19
        clr();
        add_ev(5, 1, WRITE, 10'h0F0); add_ev(6, 1, READ, 10'h00F);
        add_exp(7, WRITE, 10'h0F0); add_exp(26, READ, 10'h00F);
        add_pr(25, 5, 0); add_pr(20, 3, WRITE);
        run_scn("w2r");

        // Read to write turnaround: tRTW = 8
        clr();
        add_ev(5, 1, READ, 10'h101); add_ev(6, 1, WRITE, 10'h202);
        add_exp(7, READ, 10'h101); add_exp(15, WRITE, 10'h202);
        add_pr(14, 5, 0);
        run_scn("r2w");

        // Overflow: head held by ACT, third access dropped
        clr();
        add_ev(5, 0, READ, 10'h001); add_ev(6, 1, READ, 10'h002); add_ev(7, 1, READ, 10'h003);
        add_exp(16, READ, 10'h001); add_exp(20, READ, 10'h002);
        add_pr(7, 1, 1); add_pr(7, 2, 0); add_pr(8, 2, 1); add_pr(30, 2, 1); add_pr(21, 0, 1);
        run_scn("ovf");

        // Reset while waiting on tRCD, after a both-pulse error
        clr();
        add_ev(10, 2, READ, 10'h005);
        rst_cyc = 15;
        add_pr(11, 2, 1); add_pr(11, 0, 0); add_pr(16, 0, 1); add_pr(16, 2, 0); add_pr(16, 1, 0);
        run_scn("rst_wait");

        // Reset in the issue cycle
        clr();
        add_ev(5, 1, WRITE, 10'h3FF);
        rst_cyc = 7;
        add_exp(7, WRITE, 10'h3FF);
        add_pr(7, 4, 10'h3FF); add_pr(8, 5, 0); add_pr(8, 3, 0); add_pr(8, 4, 0); add_pr(8, 0, 1);
        run_scn("rst_issue");

        // Both pulses together: ACT timing wins, single entry
        clr();
        add_ev(5, 2, WRITE, 10'h0AA);
        add_exp(16, WRITE, 10'h0AA);
        add_pr(5, 2, 0); add_pr(6, 2, 1); add_pr(6, 1, 0);
        run_scn("both");

        // Push while full but popping: accepted
        clr();
        add_ev(5, 1, WRITE, 10'h001); add_ev(6, 1, WRITE, 10'h002); add_ev(7, 1, WRITE, 10'h003);
        add_exp(7, WRITE, 10'h001); add_exp(11, WRITE, 10'h002); add_exp(15, WRITE, 10'h003);
        add_pr(8, 2, 0); add_pr(8, 1, 1); add_pr(12, 1, 0); add_pr(16, 0, 1);
        run_scn("full_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_cas_sched.md
# ddr_cas_sched

CAS scheduler for the DDR4 controller: sits directly downstream of the ACT sequencer and turns its `act_rdy` pulses (new row opened) and `no_act_rdy` pulses (row hit) into timed CAS issue pulses. It holds up to two pending column accesses in order. It enforces tRCD from ACT to CAS, tCCD between same-direction CAS, and the write-to-read and read-to-write turnaround gaps. It also drives `cas_idle`, which the ACT sequencer samples before precharging.

## Interface
Parameters:
- `TRCD`, 11: cycles from `act_rdy` to the earliest CAS for that access.
- `TCCD`, 4: minimum cas_rdy-to-cas_rdy spacing when the direction is unchanged.
- `WL`, 9: write latency.
- `TWTR`, 6: write-to-read turnaround. The W→R gap is `WL+4+TWTR`.
- `TRTW`, 8: minimum R→W spacing.
- `COL_W`, 10: column address width.

Ports:
- `clock_t` in 1: controller clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `act_rdy` in 1: 1-cycle pulse; ACT was issued for this access.
- `no_act_rdy` in 1: 1-cycle pulse; row hit, no ACT needed.
- `act_rw` in 2: READ/WRITE (package encoding), valid with either pulse.
- `col_addr` in COL_W: column address, valid with either pulse.
- `cas_rdy` out 1: 1-cycle pulse; issue CAS now.
- `cas_rw` out 2: direction of the issued CAS; holds its value until the next issue.
- `cas_col` out COL_W: column of the issued CAS; holds its value until the next issue.
- `cas_idle` out 1: high when the queue is empty and no issue is in flight.
- `q_full` out 1: both queue entries occupied.
- `err_ovf` out 1: sticky; push attempted while full, or both pulses in one cycle.

## Operation
- **Queue.** 2-entry in-order FIFO; each entry holds {rw, col, rcd_cnt}.
  - Push on `act_rdy`: rcd_cnt = TRCD-1.
  - Push on `no_act_rdy`: rcd_cnt = 0.
  - rcd_cnt decrements each cycle, saturating at 0. Only the head entry may issue.
- **Eligibility.** The head is eligible when rcd_cnt==0 and the direction gap since the last CAS is met:
  - same direction: ≥TCCD cycles
  - W→R: ≥WL+4+TWTR cycles
  - R→W: ≥TRTW cycles
- **Gap counter.** 6 bits; zeroed on each issue; increments and saturates at 63. All gap parameters must be <63; the package checks this with a static assertion.
- **FSM states** (`cas_fsm_type`):
  - CAS_IDLE: queue empty, `cas_idle`=1. → CAS_WAIT on push.
  - CAS_WAIT: `cas_idle`=0. → CAS_ISSUE when the head is eligible.
  - CAS_ISSUE: `cas_rdy`=1; pop the head; latch `cas_rw`/`cas_col`; record last_rw. → CAS_WAIT if the queue is still non-empty, else CAS_IDLE.
- **Simultaneous events:**
  - Push and pop in the same cycle while full: accepted, no overflow.
  - Push while full with no pop: input dropped, `err_ovf` set.
  - `act_rdy` and `no_act_rdy` together: `act_rdy` wins, `err_ovf` set.
- **After reset:** last_rw is invalid, so no turnaround gap applies to the first CAS.
- **Reset (including mid-issue).** Next cycle:
  - queue empty, FSM in CAS_IDLE
  - `cas_rdy`=0, `cas_rw`=0, `cas_col`=0
  - `cas_idle`=1, `q_full`=0, `err_ovf`=0
  - gap counter = 63 (saturated)

## Timing
- All outputs are registered.
- `act_rdy` at cycle N → earliest `cas_rdy` at N+TRCD.
- `no_act_rdy` at N → earliest `cas_rdy` at N+2 (push in N+1, issue in N+2).
- `cas_rdy` at M → the next `cas_rdy` no earlier than M+gap, where gap is the applicable value above.
- `cas_idle` falls the cycle after a push into an empty queue. It rises the cycle after the final issue.
- `q_full` updates the cycle after a push or pop.

## Structure
- Shared package gets:
  - `cas_fsm_type` {CAS_IDLE, CAS_WAIT, CAS_ISSUE}
  - READ/WRITE encodings (reused)
  - default timing constants (tRCD, tCCD, tWTR, tRTW, WL)
  - gap-width static check
- One sub-module, `cas_gap_timer`: takes the last/next direction and the issue pulse; outputs `gap_ok`.

## Test plan
- **Act then read:** `act_rdy`+READ at cycle 10 → `cas_rdy` at 21; `cas_rw`=READ; `cas_idle` high from 22.
- **Back-to-back hits:** `no_act_rdy`+WRITE at cycles 5 and 6 → `cas_rdy` at 7 and 11 (TCCD=4).
- **W→R turnaround:** WRITE hit at 5, READ hit at 6 → `cas_rdy` at 7 and 26 (7+19).
- **R→W turnaround:** READ hit at 5, WRITE hit at 6 → `cas_rdy` at 7 and 15.
- **Overflow:** three hits at cycles 5, 6, 7 with the first entry held by an `act_rdy` → third access dropped, `err_ovf`=1; issues = first two only.
- **Reset mid-wait:** `act_rdy` at 10, `reset` at 15 → no `cas_rdy` afterward; `cas_idle`=1 and `err_ovf`=0 at 16.
